if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32 pipeline: owns the PC, issues single-outstanding requests to the instruction memory wrapper, and drives the IF/ID pipeline register that feeds the decode-stage Control and immediate-generator blocks. Handles decode stalls from the hazard unit, and EX-stage redirects (branch/jump) with flush and discard of stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction word driven on id_inst when IF/ID holds a bubble (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
redirect_valid  in  1  EX-stage redirect (taken branch/jump), single-cycle pulse
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
id_stall  in  1  decode cannot accept; IF/ID must hold
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response data valid (>=1 cycle after accept)
imem_rsp_data  in  32  instruction word
id_valid  out  1  IF/ID holds a valid instruction
id_pc  out  32  PC of id_inst
id_inst  out  32  instruction to decode

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=REQ, discard=0, hold buffer empty, id_valid=0, id_pc=0, id_inst=NOP_INST, imem_req_valid=0 during reset cycle; all in-flight transactions forgotten.
- States: REQ, WAIT, HOLD. One outstanding request max.
- REQ: imem_req_valid=1, imem_req_addr=pc. On valid&ready: inflight_pc<=pc, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), ->WAIT. imem_rsp_valid in REQ is ignored.
- WAIT: imem_req_valid=0. On imem_rsp_valid:
  - discard=1: drop data, discard<=0, ->REQ.
  - IF/ID free (id_valid=0 or id_stall=0): id_inst<=data, id_pc<=inflight_pc, id_valid<=1, ->REQ.
  - else: hold_inst/hold_pc<=data/inflight_pc, ->HOLD.
- HOLD: imem_req_valid=0; when id_stall=0 move hold into IF/ID (id_valid=1), ->REQ.
- IF/ID consumption: when id_stall=0 and nothing loads this cycle, id_valid<=0, id_inst<=NOP_INST. When id_stall=1, IF/ID holds all values.
- Latency: accept at cycle N, response at N+k (k>=1) -> id_valid at N+k+1. Peak throughput 1 instr / 2 cycles.
- Redirect (highest priority, overrides id_stall):
  - pc<=redirect_pc&~3; id_valid<=0, id_inst<=NOP_INST; hold buffer cleared.
  - WAIT without same-cycle response: stay WAIT, discard<=1.
  - WAIT with same-cycle response: response dropped, ->REQ.
  - REQ with same-cycle accept: accepted request is stale -> WAIT, discard<=1.
  - REQ without accept: stay REQ; next cycle imem_req_addr=new pc.
  - HOLD: ->REQ.
  - Redirect while discard already 1: discard stays 1.
- Memory wrapper tolerates imem_req_addr changing while unaccepted; that occurs only after a redirect.
- imem_rsp_valid outside WAIT never creates id_valid.

Optional Feature:
Macro FETCH_PERF_EN. Defined: adds outputs perf_fetch_cnt[31:0] (increments on each instruction loaded into IF/ID) and perf_bubble_cnt[31:0] (increments each cycle id_valid=0 and id_stall=0); both reset to 0, wrap at 2^32, unaffected by redirect. Undefined: ports and counters absent, all other behaviour identical.

Test Plan:
- Reset, imem ready=1, 1-cycle response latency, data 32'h00000013 / 32'h00100093 -> first accept addr 0x0, id_valid at cycle 3 with id_pc=0x0, next id_pc=0x4; imem_req_addr sequence 0x0,0x4,0x8.
- id_stall=1 for 4 cycles while response 32'h00208133 arrives -> HOLD entered, IF/ID unchanged, no new request; stall released -> id_inst=32'h00208133, id_pc correct, request resumes.
- Redirect to 0x100 in WAIT, response arrives 2 cycles later -> response dropped, id_valid stays 0, next request addr 0x100.
- Redirect to 0x203 same cycle as request accept -> that response discarded, next addr 0x200; redirect with id_stall=1 -> id_valid=0, id_inst=NOP_INST.
- PC at 32'hFFFF_FFFC fetched -> next imem_req_addr=0x0.
- rst_n=0 for one cycle during WAIT, stale response arrives after -> ignored; first request addr=RESET_PC; with FETCH_PERF_EN counters read 0 after reset and count 3 after 3 fetches.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the 5-stage RV32 pipeline.
// Owns the PC and issues at most one outstanding request to the instruction
// memory wrapper. Drives the IF/ID register that feeds decode. A three-state
// controller handles the request, the wait for the response, and holding a
// response while decode is stalled.
// EX-stage redirects reload the PC. They flush IF/ID and mark any in-flight
// response as stale.
// Optional build macro FETCH_PERF_EN adds the fetch and bubble performance
// counters perf_fetch_cnt and perf_bubble_cnt.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_discard;
  logic [31:0] r_hold_inst;
  logic [31:0] r_hold_pc;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;

  logic [31:0] w_redirect_target;
  logic [31:0] w_pc_inc;
  logic        w_idif_free;
  logic        w_rsp_keep;
  logic        w_load_rsp;
  logic        w_to_hold;
  logic        w_load_hold;
  logic        w_load;
  logic [31:0] w_load_inst;
  logic [31:0] w_load_pc;

  // Redirect targets are forced word-aligned; the sequential PC wraps at 2^32.
  assign w_redirect_target = redirect_pc & ~32'd3;
  assign w_pc_inc          = r_pc + 32'd4;

  // IF/ID can take a new instruction if it is empty or being consumed now.
  assign w_idif_free = !r_id_valid || !id_stall;

  // A response is useful only in WAIT, when it is not stale and no redirect
  // is killing it this cycle.
  assign w_rsp_keep  = (r_state == ST_WAIT) && imem_rsp_valid && !r_discard && !redirect_valid;
  assign w_load_rsp  = w_rsp_keep && w_idif_free;
  assign w_to_hold   = w_rsp_keep && !w_idif_free;
  assign w_load_hold = (r_state == ST_HOLD) && !id_stall && !redirect_valid;
  assign w_load      = w_load_rsp || w_load_hold;
  assign w_load_inst = w_load_hold ? r_hold_inst : imem_rsp_data;
  assign w_load_pc   = w_load_hold ? r_hold_pc : r_inflight_pc;

  // A request is only presented in REQ. It is suppressed while reset is held.
  assign imem_req_valid = rst_n && (r_state == ST_REQ);
  assign imem_req_addr  = r_pc;

  assign id_valid = r_id_valid;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;

  // Fetch controller: the PC, the state and the stale-response flag.
  // A redirect takes priority over everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= 32'd0;
      r_discard     <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
      case (r_state)
        ST_REQ: begin
          if (imem_req_ready) begin
            r_state   <= ST_WAIT;
            r_discard <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            r_state   <= ST_REQ;
            r_discard <= 1'b0;
          end else begin
            r_discard <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_REQ;
        end
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (imem_req_ready) begin
            r_inflight_pc <= r_pc;
            r_pc          <= w_pc_inc;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            r_discard <= 1'b0;
            if (r_discard || w_idif_free) begin
              r_state <= ST_REQ;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!id_stall) begin
            r_state <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_REQ;
        end
      endcase
    end
  end

  // Hold buffer: parks a response that arrived while decode was stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_inst <= 32'd0;
      r_hold_pc   <= 32'd0;
    end else if (redirect_valid) begin
      r_hold_inst <= 32'd0;
      r_hold_pc   <= 32'd0;
    end else if (w_to_hold) begin
      r_hold_inst <= imem_rsp_data;
      r_hold_pc   <= r_inflight_pc;
    end
  end

  // IF/ID register: flushed by a redirect, loaded by a fresh instruction,
  // emptied to a bubble when consumed, and frozen while decode stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'd0;
      r_id_inst  <= NOP_INST;
    end else if (redirect_valid) begin
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
    end else if (w_load) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= w_load_pc;
      r_id_inst  <= w_load_inst;
    end else if (!id_stall) begin
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_bubble_cnt;

  assign perf_fetch_cnt  = r_perf_fetch_cnt;
  assign perf_bubble_cnt = r_perf_bubble_cnt;

  // Performance counters: instructions delivered to decode, and empty
  // cycles that decode was ready to accept. Redirects do not affect them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetch_cnt  <= 32'd0;
      r_perf_bubble_cnt <= 32'd0;
    end else begin
      if (w_load) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (!r_id_valid && !id_stall) begin
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench for if_fetch_stage. It has a
// behavioural instruction memory with programmable response latency.
// A scoreboard holds the expected IF/ID instructions in order.
// Perf counter checks are compiled only when FETCH_PERF_EN is defined.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetchT;

  fetchT       expQ[$];
  int          checks;
  int          failures;
  logic        memBusy;
  logic [31:0] memAddr;
  int          memDelay;
  int          memLat;
  logic        prevValid;
  logic        prevStall;
  int          bubbleExp;

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: a few fixed words, otherwise address-derived.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0008: return 32'h0020_8133;
      default:       return addr ^ 32'hC0DE_0000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expectFetch(input logic [31:0] pc);
    fetchT e;
    e.pc   = pc;
    e.inst = memWord(pc);
    expQ.push_back(e);
  endtask

  // Detect each new instruction appearing in IF/ID and compare it against
  // the scoreboard. Also track the expected bubble count.
  task automatic monitorSample();
    fetchT e;
    if (!rst_n) begin
      bubbleExp = 0;
      prevValid = 1'b0;
    end else begin
      if (!id_valid && !id_stall) bubbleExp++;
      if (id_valid && (!prevValid || !prevStall)) begin
        checks++;
        assert (expQ.size() > 0) else begin
          failures++;
          $error("[TB] FAIL sb_unexpected observed pc=%h expected=no instruction", id_pc);
        end
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("sb_pc", id_pc, e.pc);
          checkOutput("sb_inst", id_inst, e.inst);
        end
      end
      prevValid = id_valid;
    end
    prevStall = id_stall;
  endtask

  // Set this cycle's inputs shortly after the rising edge.
  task automatic applyStimulus(input logic rstN, input logic redir, input logic [31:0] rpc,
                               input logic stall, input logic ready);
    rst_n          = rstN;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_stall       = stall;
    imem_req_ready = ready;
    #1;
  endtask

  // Finish the cycle: monitor at the falling edge, latch an accepted request
  // just before the rising edge, then drive the memory response for the next cycle.
  task automatic advance();
    #3;
    monitorSample();
    #4;
    if (imem_req_valid && imem_req_ready) begin
      memBusy  = 1'b1;
      memAddr  = imem_req_addr;
      memDelay = memLat;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if (memBusy) begin
      memDelay--;
      if (memDelay == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memWord(memAddr);
        memBusy        = 1'b0;
      end
    end
  endtask

  // Directed sequence of fetch, stall, redirect, wrap and reset scenarios.
  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; id_stall = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    memBusy = 1'b0; memAddr = 32'd0; memDelay = 0; memLat = 1;
    prevValid = 1'b0; prevStall = 1'b0; bubbleExp = 0;
    @(posedge clk);
    #1;

    // C0: reset cycle
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    advance();
    // C1: reset state visible, first request at RESET_PC
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("rst_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("rst_id_pc", id_pc, 32'd0);
    checkOutput("rst_id_inst", id_inst, NOP);
    checkOutput("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    checkOutput("perf_bubble_rst", perf_bubble_cnt, 32'd0);
`endif
    expectFetch(32'h0);
    advance();
    // C2: WAIT, response arrives
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("wait_id_valid", {31'd0, id_valid}, 32'd0);
    advance();
    // C3: first instruction in IF/ID
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("lat_id_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("seq_req_addr4", imem_req_addr, 32'h4);
    expectFetch(32'h4);
    advance();
    // C4
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("consume_id_valid", {31'd0, id_valid}, 32'd0);
    advance();
    // C5: stall begins, request for 0x8 accepted
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("seq_req_addr8", imem_req_addr, 32'h8);
    expectFetch(32'h8);
    advance();
    // C6: response arrives during stall
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("stall_wait_req", {31'd0, imem_req_valid}, 32'd0);
    advance();
    // C7: HOLD
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("hold_id_pc", id_pc, 32'h4);
    checkOutput("hold_id_inst", id_inst, 32'h0010_0093);
    advance();
    // C8
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("hold_no_req2", {31'd0, imem_req_valid}, 32'd0);
    advance();
    // C9: stall released
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("release_id_pc_old", id_pc, 32'h4);
    checkOutput("release_no_req", {31'd0, imem_req_valid}, 32'd0);
    advance();
    // C10: held instruction delivered; next request with latency 3
    memLat = 3;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("release_id_pc", id_pc, 32'h8);
    checkOutput("release_id_inst", id_inst, 32'h0020_8133);
    checkOutput("resume_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("resume_req_addr", imem_req_addr, 32'hC);
    advance();
    // C11: redirect to 0x100 in WAIT
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
    checkOutput("redir_wait_req", {31'd0, imem_req_valid}, 32'd0);
    advance();
    // C12
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("redir_wait_stay", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("redir_id_valid", {31'd0, id_valid}, 32'd0);
    advance();
    // C13: stale response arrives
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("stale_wait_req", {31'd0, imem_req_valid}, 32'd0);
    advance();
    // C14: request 0x100 accepted with simultaneous redirect to 0x203
    memLat = 1;
    applyStimulus(1'b1, 1'b1, 32'h203, 1'b0, 1'b1);
    checkOutput("drop_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("redir_req_addr", imem_req_addr, 32'h100);
    advance();
    // C15: stale response for 0x100 dropped
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("accept_redir_wait", {31'd0, imem_req_valid}, 32'd0);
    advance();
    // C16
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("accept_redir_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("aligned_req_addr", imem_req_addr, 32'h200);
    expectFetch(32'h200);
    advance();
    // C17
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    advance();
    // C18: 0x200 in IF/ID, stall, request 0x204 accepted
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    advance();
    // C19: redirect under stall, same cycle as response
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    checkOutput("stall_held_valid", {31'd0, id_valid}, 32'd1);
    advance();
    // C20
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("redir_stall_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("redir_stall_inst", id_inst, NOP);
    checkOutput("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    expectFetch(32'hFFFF_FFFC);
    advance();
    // C21
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    advance();
    // C22: wrap; request at 0 accepted with latency 3
    memLat = 3;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("top_id_pc", id_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_req_addr", imem_req_addr, 32'h0);
    advance();
    // C23: reset during WAIT
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("rst_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    advance();
    // C24: out of reset, memory not ready
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("rst2_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("rst2_req_addr", imem_req_addr, 32'h0);
    checkOutput("rst2_id_pc", id_pc, 32'd0);
    checkOutput("rst2_id_valid", {31'd0, id_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetch_rst2", perf_fetch_cnt, 32'd0);
    checkOutput("perf_bubble_rst2", perf_bubble_cnt, 32'd0);
`endif
    advance();
    // C25: stale response while in REQ
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    advance();
    // C26
    memLat = 1;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("stale_ignored", {31'd0, id_valid}, 32'd0);
    checkOutput("rst2_req_valid2", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("rst2_req_addr2", imem_req_addr, 32'h0);
    expectFetch(32'h0);
    advance();
    // C27..C31: three back-to-back fetches
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    advance();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("tput_req_addr4", imem_req_addr, 32'h4);
    expectFetch(32'h4);
    advance();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    advance();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("tput_req_addr8", imem_req_addr, 32'h8);
    expectFetch(32'h8);
    advance();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    advance();
    // C32, C33: memory stops accepting
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    advance();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetch_3", perf_fetch_cnt, 32'd3);
    checkOutput("perf_bubble", perf_bubble_cnt, bubbleExp);
`endif
    advance();

    checkOutput("sb_drain", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
